// File: rtl/timer_sequencer.sv
// ---------------------------------------------------------------------------
// timer_sequencer
//
// Initiator side of the enable/done timer interface. Each accepted request
// walks an external timer through NUM_PHASES timed phases. Every phase is a
// one-cycle GAP with the enable low, which clears the timer's counter,
// followed by RUN with the enable high until the timer reports done. A
// watchdog aborts a RUN that never completes and raises a sticky error.
//
// Handshakes (all outputs are registered):
//   start/busy  : start is sampled only while idle; busy rises the cycle after
//                 an accepted start and falls in the seq_done, abort or
//                 watchdog cycle. start while busy is ignored.
//   enable/done : tmr_enable is held high for the whole of RUN. tmr_done is a
//                 level that stays high until the enable drops, so it is
//                 ignored during GAP.
//   same-edge priority: abort > tmr_done > watchdog expiry.
//
// Ports:
//   clk          in   system clock, rising edge
//   rst          in   asynchronous active-high reset
//   start        in   request a sequence (IDLE only)
//   abort        in   end any sequence in progress, back to IDLE
//   loop_en      in   at last-phase completion, restart at phase 0
//   tmr_done     in   completion level from the external timer
//   tmr_enable   out  enable to the external timer
//   busy         out  sequence in progress
//   phase        out  index of the current phase
//   phase_strobe out  one-cycle pulse per completed phase
//   seq_done     out  one-cycle pulse on normal completion
//   error        out  sticky watchdog flag, cleared by the next accepted start
// ---------------------------------------------------------------------------
module timer_sequencer #(
  parameter int  NUM_PHASES  = 4,
  parameter int  WDOG_CYCLES = 1024,
  localparam int PHASE_W     = $clog2(NUM_PHASES),
  localparam int WDOG_W      = $clog2(WDOG_CYCLES) + 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               abort,
  input  logic               loop_en,
  input  logic               tmr_done,
  output logic               tmr_enable,
  output logic               busy,
  output logic [PHASE_W-1:0] phase,
  output logic               phase_strobe,
  output logic               seq_done,
  output logic               error
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_GAP  = 2'd1,
    S_RUN  = 2'd2
  } state_t;

  localparam logic [PHASE_W-1:0] LAST_PHASE = PHASE_W'(NUM_PHASES - 1);
  localparam logic [WDOG_W-1:0]  WDOG_LAST  = WDOG_W'(WDOG_CYCLES - 1);

  // Current sequencer state; kept as a named enum so checkers can bind to it.
  state_t              state;
  // Counts RUN cycles of the current phase; reads k-1 in the k-th RUN cycle.
  logic [WDOG_W-1:0]   wdog_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= S_IDLE;
      tmr_enable   <= 1'b0;
      busy         <= 1'b0;
      phase        <= '0;
      phase_strobe <= 1'b0;
      seq_done     <= 1'b0;
      error        <= 1'b0;
      wdog_cnt     <= '0;
    end else begin
      // Pulses default low; only the completion branches raise them.
      phase_strobe <= 1'b0;
      seq_done     <= 1'b0;

      case (state)
        S_IDLE: begin
          if (start && !abort) begin
            state      <= S_GAP;
            busy       <= 1'b1;
            phase      <= '0;
            error      <= 1'b0;
            tmr_enable <= 1'b0;
            wdog_cnt   <= '0;
          end
        end

        S_GAP: begin
          if (abort) begin
            state      <= S_IDLE;
            tmr_enable <= 1'b0;
            busy       <= 1'b0;
            phase      <= '0;
          end else begin
            // tmr_done may still be high from the previous phase; not looked at.
            state      <= S_RUN;
            tmr_enable <= 1'b1;
            wdog_cnt   <= '0;
          end
        end

        S_RUN: begin
          if (abort) begin
            state      <= S_IDLE;
            tmr_enable <= 1'b0;
            busy       <= 1'b0;
            phase      <= '0;
          end else if (tmr_done) begin
            phase_strobe <= 1'b1;
            tmr_enable   <= 1'b0;
            if (phase != LAST_PHASE) begin
              phase <= phase + PHASE_W'(1);
              state <= S_GAP;
            end else if (loop_en) begin
              phase <= '0;
              state <= S_GAP;
            end else begin
              phase    <= '0;
              state    <= S_IDLE;
              busy     <= 1'b0;
              seq_done <= 1'b1;
            end
          end else if (wdog_cnt == WDOG_LAST) begin
            // Timer never answered: give up on the whole sequence.
            state      <= S_IDLE;
            tmr_enable <= 1'b0;
            busy       <= 1'b0;
            phase      <= '0;
            error      <= 1'b1;
          end else begin
            wdog_cnt <= wdog_cnt + WDOG_W'(1);
          end
        end

        default: begin
          state      <= S_IDLE;
          tmr_enable <= 1'b0;
          busy       <= 1'b0;
          phase      <= '0;
        end
      endcase
    end
  end

endmodule
